memory_access_ctrl: RTL and testbench

Host-side initiator for the 8x8 latch-bitcell memory unit. It accepts single-word read and write requests over a valid/ready handshake and sequences the memory's op/select/address/in_bus pins through setup, strobe and hold phases so that the latch-based wordcells see stable address, data and op before and after select. It registers the memory's out_bus on reads and returns a response over a second valid/ready handshake.

---
 rtl/memory_access_ctrl.sv | 135 +++++++++++++
 tb/tb_memory_access_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : memory_access_ctrl
// Description : Host-side initiator for the 8x8 latch-bitcell memory. Takes
//               single-word read/write requests over a valid/ready handshake,
//               sequences op/select/address/in_bus through setup, strobe and
//               hold phases, and returns a response over a second handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   req_valid   in   request present
//   req_ready   out  controller can accept a request (IDLE decode)
//   req_write   in   1 = write, 0 = read
//   req_addr    in   word address
//   req_wdata   in   write data
//   rsp_valid   out  response present
//   rsp_ready   in   host accepts response
//   rsp_write   out  echo of req_write for this response
//   rsp_rdata   out  read data (0 for writes)
//   mem_op      out  memory op: 1 = write, 0 = read
//   mem_select  out  memory select strobe
//   mem_address out  memory address
//   mem_in_bus  out  memory write data
//   mem_out_bus in   memory read data
// ============================================================================
module memory_access_ctrl #(
  parameter int ADDR_W     = 3,
  parameter int DATA_W     = 8,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_op,
  output logic              mem_select,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in_bus,
  input  logic [DATA_W-1:0] mem_out_bus
);

  localparam int MAX_CYC = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             setup_done;
  logic             strobe_done;

  // The counter holds the number of cycles already spent in the current
  // phase, so the phase ends when it reaches its length minus one.
  assign setup_done  = (cnt == CNT_W'(SETUP_CYC - 1));
  assign strobe_done = (cnt == CNT_W'(STROBE_CYC - 1));

  // Only IDLE accepts requests; decoding from the state register keeps the
  // request side free of any input-to-output combinational path.
  assign req_ready = (state == IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid)   state_nxt = SETUP;
      SETUP:   if (setup_done)  state_nxt = STROBE;
      STROBE:  if (strobe_done) state_nxt = HOLD;
      HOLD:                     state_nxt = RESP;
      RESP:    if (rsp_ready)   state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
      mem_op      <= 1'b0;
      mem_select  <= 1'b0;
      mem_address <= '0;
      mem_in_bus  <= '0;
    end else begin
      state <= state_nxt;

      // Counter restarts on every phase change; it only advances in the
      // timed phases so it cannot wrap while parked in IDLE or RESP.
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (state == SETUP || state == STROBE) begin
        cnt <= cnt + 1'b1;
      end

      // Select and response-valid are registered versions of the next
      // state, so they rise and fall exactly on the phase boundaries.
      mem_select <= (state_nxt == STROBE);
      rsp_valid  <= (state_nxt == RESP);

      // Memory-side command is captured only at the accept edge and then
      // held through setup, strobe, hold and the response phase.
      if (state == IDLE && req_valid) begin
        mem_op      <= req_write;
        rsp_write   <= req_write;
        mem_address <= req_addr;
        mem_in_bus  <= req_write ? req_wdata : '0;
      end

      // Read data is sampled at the edge that closes the strobe window,
      // while the wordcell is still selected and driving out_bus.
      if (state == STROBE && strobe_done) begin
        rsp_rdata <= mem_op ? '0 : mem_out_bus;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_access_ctrl
// Description : Directed self-checking bench for memory_access_ctrl with a
//               behavioural 8x8 memory model. A second instance runs with
//               SETUP_CYC=3, STROBE_CYC=2 for phase timing checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_access_ctrl;

  logic       clk;
  logic       rst_n;

  // default-parameter instance
  logic       req_valid, req_ready, req_write;
  logic [2:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_ready, rsp_write;
  logic [7:0] rsp_rdata;
  logic       mem_op, mem_select;
  logic [2:0] mem_address;
  logic [7:0] mem_in_bus, mem_out_bus;

  // SETUP_CYC=3 / STROBE_CYC=2 instance
  logic       req_valid1, req_ready1, req_write1;
  logic [2:0] req_addr1;
  logic [7:0] req_wdata1;
  logic       rsp_valid1, rsp_ready1, rsp_write1;
  logic [7:0] rsp_rdata1;
  logic       mem_op1, mem_select1;
  logic [2:0] mem_address1;
  logic [7:0] mem_in_bus1;

  int n_checks;
  int n_errors;
  int pulses0;
  logic sel_prev0;
  logic [7:0] mem [8];

  memory_access_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata),
    .mem_op(mem_op), .mem_select(mem_select), .mem_address(mem_address),
    .mem_in_bus(mem_in_bus), .mem_out_bus(mem_out_bus)
  );

  memory_access_ctrl #(.ADDR_W(3), .DATA_W(8), .SETUP_CYC(3), .STROBE_CYC(2)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
    .req_addr(req_addr1), .req_wdata(req_wdata1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_write(rsp_write1),
    .rsp_rdata(rsp_rdata1),
    .mem_op(mem_op1), .mem_select(mem_select1), .mem_address(mem_address1),
    .mem_in_bus(mem_in_bus1), .mem_out_bus(8'h00)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: wordcell written while selected with op=1; out_bus drives
  // the addressed word only while selected for a read.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
    end else if (mem_select && mem_op) begin
      mem[mem_address] <= mem_in_bus;
    end
  end
  assign mem_out_bus = (mem_select && !mem_op) ? mem[mem_address] : 8'h00;

  // Select pulse counter, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_select && !sel_prev0) pulses0 <= pulses0 + 1;
    sel_prev0 <= mem_select;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on the default instance with rsp_ready high.
  // Default timing: edges E1..E3 after the accept edge are setup->strobe,
  // strobe->hold, hold->resp, so rsp_valid is first seen 3 edges later.
  task automatic xact(input logic w, input logic [2:0] a, input logic [7:0] d,
                      input logic [7:0] exp);
    int lat;
    int p0;
    p0        = pulses0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    check("xact_req_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    check("xact_addr", mem_address, a);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("xact_latency", lat, 3);
    check("xact_rsp_write", rsp_write, w);
    check("xact_rsp_rdata", rsp_rdata, exp);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("xact_pulses", pulses0 - p0, 1);
    check("xact_back_idle", req_ready, 1);
  endtask

  initial begin
    int lat;
    n_checks   = 0;
    n_errors   = 0;
    pulses0    = 0;
    sel_prev0  = 1'b0;
    rst_n      = 1'b0;
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_addr   = 3'd3;
    req_wdata  = 8'h5A;
    rsp_ready  = 1'b0;
    req_valid1 = 1'b0;
    req_write1 = 1'b0;
    req_addr1  = 3'd0;
    req_wdata1 = 8'h00;
    rsp_ready1 = 1'b0;

    // Reset held with a pending request: nothing moves.
    repeat (3) tick();
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_write", rsp_write, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_mem_op", mem_op, 0);
    check("rst_mem_select", mem_select, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_mem_in_bus", mem_in_bus, 0);
    check("rst_no_pulse", pulses0, 0);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Write addr 5 data A5 with cycle-exact phase checks.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 3'd5;
    req_wdata = 8'hA5;
    tick();                                   // accept edge
    req_valid = 1'b0;
    check("wr_mem_op", mem_op, 1);
    check("wr_mem_address", mem_address, 5);
    check("wr_mem_in_bus", mem_in_bus, 8'hA5);
    check("wr_setup_sel", mem_select, 0);
    check("wr_busy", req_ready, 0);
    tick();
    check("wr_strobe_sel", mem_select, 1);
    tick();
    check("wr_hold_sel", mem_select, 0);
    check("wr_hold_rsp", rsp_valid, 0);
    check("wr_hold_addr", mem_address, 5);
    tick();
    check("wr_rsp_valid", rsp_valid, 1);
    check("wr_rsp_write", rsp_write, 1);
    check("wr_rsp_rdata", rsp_rdata, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("wr_rsp_drop", rsp_valid, 0);
    check("wr_idle_ready", req_ready, 1);
    check("wr_pulses", pulses0, 1);

    // Read back the word just written.
    xact(1'b0, 3'd5, 8'hFF, 8'hA5);
    check("rd_mem_op", mem_op, 0);

    // Backpressure on a read of 0x3C, with a second request waiting.
    xact(1'b1, 3'd2, 8'h3C, 8'h00);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 3'd2;
    tick();
    req_addr  = 3'd0;                         // second request, held pending
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("bp_latency", lat, 3);
    for (int i = 0; i < 6; i++) begin
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_rdata", rsp_rdata, 8'h3C);
      check("bp_req_ready", req_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_rsp_drop", rsp_valid, 0);
    check("bp_no_same_cycle_accept", mem_address, 2);
    check("bp_ready_after", req_ready, 1);
    tick();
    req_valid = 1'b0;
    check("bp_second_accept", mem_address, 0);
    check("bp_second_busy", req_ready, 0);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("bp2_latency", lat, 3);
    check("bp2_rdata", rsp_rdata, 8'h00);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Back-to-back: 8 writes then 8 reads.
    for (int i = 0; i < 8; i++) xact(1'b1, 3'(i), 8'(i * 8'h11), 8'h00);
    for (int i = 0; i < 8; i++) xact(1'b0, 3'(i), 8'h00, 8'(i * 8'h11));

    // SETUP_CYC=3, STROBE_CYC=2 instance: write addr 7 data FF.
    // After accept edge Ek: setup for k=0..2, strobe k=3..4, hold k=5, resp k=6.
    req_valid1 = 1'b1;
    req_write1 = 1'b1;
    req_addr1  = 3'd7;
    req_wdata1 = 8'hFF;
    tick();
    req_valid1 = 1'b0;
    for (int k = 0; k < 7; k++) begin
      check("sw_select", mem_select1, (k == 3 || k == 4) ? 1 : 0);
      check("sw_rsp_valid", rsp_valid1, (k == 6) ? 1 : 0);
      check("sw_addr", mem_address1, 7);
      check("sw_data", mem_in_bus1, 8'hFF);
      check("sw_op", mem_op1, 1);
      if (k < 6) tick();
    end
    check("sw_rsp_write", rsp_write1, 1);
    rsp_ready1 = 1'b1;
    tick();
    rsp_ready1 = 1'b0;
    check("sw_idle", req_ready1, 1);

    // Asynchronous reset in the middle of a strobe.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 3'd6;
    req_wdata = 8'h66;
    tick();
    req_valid = 1'b0;
    tick();
    check("ar_in_strobe", mem_select, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_select_low", mem_select, 0);
    check("ar_addr_clr", mem_address, 0);
    check("ar_op_clr", mem_op, 0);
    check("ar_ready", req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick();
    check("ar_no_rsp", rsp_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
